// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war game logic.
//   cpu_state_t : states of the computer-opponent press generator
//   CPU_DIFF_W  : default width of the difficulty switches
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } cpu_state_t;

    localparam int CPU_DIFF_W = 9;

endpackage

// File: rtl/lfsr_xnor.sv
// Fibonacci XNOR linear-feedback shift register.
// The XNOR form makes all-zeros a legal state, so reset can clear the register.
// All-ones is the one lock-up value, and the sequence never reaches it.
//   clk   in   1  clock
//   reset in   1  synchronous, active-high; clears q to 0
//   adv   in   1  advance one step this cycle
//   q     out  W  current register state
module lfsr_xnor #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] q
);

    // Taps at bit positions W and W-3 (1-based), e.g. 10,7 for W=10.
    logic feedback;
    assign feedback = ~(q[W-1] ^ q[W-4]);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (adv)
            q <= {q[W-2:0], feedback};
    end

endmodule

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war. It emits single-cycle key-press pulses at a
// pseudo-random rate set by the difficulty switches. press feeds the R input of
// every light FSM. Those FSMs act on every cycle the key is high, so a press is
// never wider than one cycle.
//   clk        in   1         clock
//   reset      in   1         synchronous, active-high
//   tick       in   1         sample strobe; LFSR steps and press attempts only on tick
//   enable     in   1         game running; low once a winner is declared
//   difficulty in   DIFF_W    higher value = more frequent presses
//   press      out  1         one-cycle press pulse
//   lfsr_q     out  DIFF_W+1  current LFSR state (debug)
module cpu_player
    import tug_pkg::*;
#(
    parameter int DIFF_W   = CPU_DIFF_W,
    parameter int COOLDOWN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic [DIFF_W-1:0] difficulty,
    output logic              press,
    output logic [DIFF_W:0]   lfsr_q
);

    // A cooldown of 0 would give a zero-width counter, so keep at least one bit.
    localparam int               CNT_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cpu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // The LFSR keeps stepping while the game is stopped, so the press pattern
    // of the next game does not repeat the last one.
    lfsr_xnor #(.W(DIFF_W + 1)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (tick),
        .q     (lfsr_q)
    );

    // Compare against the LFSR value before this cycle's step.
    assign hit = ({1'b0, difficulty} > lfsr_q);

    // Decode press from the registered state, gated by enable. A pulse already
    // in flight is dropped when the game stops in that same cycle.
    assign press = (state_q == PRESS) && enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first. Any path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick && hit)
                        state_d = PRESS;
                end
                PRESS: begin
                    if (COOLDOWN == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                HOLD: begin
                    // The cooldown counts ticks, not clock cycles.
                    if (tick) begin
                        if (cnt_q == CNT_ONE)
                            state_d = IDLE;
                        else
                            cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
